// File: rtl/wb_stage_ctrl_pkg.sv
// riscv_wb_pkg: writeback select codes, load funct3 codes and FSM states.
// Rev 1.0
`default_nettype none

package riscv_wb_pkg;

  typedef enum logic [2:0] {
    WB_PC4   = 3'b000,
    WB_ALU   = 3'b001,
    WB_AUIPC = 3'b010,
    WB_LOAD  = 3'b011,
    WB_CSR   = 3'b100,
    WB_LUI   = 3'b111
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_stage_ctrl_load_extend.sv
// load_extend: selects the byte/half/word lane of a memory word and sign/zero-extends it.
// Rev 1.0
`default_nettype none

module load_extend
  import riscv_wb_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  output logic [XLEN-1:0]  result
);

  logic [OFF_W-1:0] half_off;
  logic [XLEN-1:0]  byte_sh;
  logic [XLEN-1:0]  half_sh;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [XLEN-1:0]  word_sx;
  logic [XLEN-1:0]  word_zx;
  logic [XLEN-1:0]  dword;

  // Half lanes ignore offset bit 0; misaligned cases never reach this stage.
  assign half_off = {off[OFF_W-1:1], 1'b0};
  assign byte_sh  = rdata >> {off, 3'b000};
  assign half_sh  = rdata >> {half_off, 3'b000};
  assign byte_v   = byte_sh[7:0];
  assign half_v   = half_sh[15:0];

  if (XLEN == 64) begin : g_x64
    logic [31:0] word_v;
    assign word_v  = off[OFF_W-1] ? rdata[XLEN-1:XLEN/2] : rdata[XLEN/2-1:0];
    assign word_sx = {{32{word_v[31]}}, word_v};
    assign word_zx = {32'b0, word_v};
    assign dword   = rdata;
  end else begin : g_x32
    // On RV32 LD and LWU collapse onto a plain LW.
    assign word_sx = rdata;
    assign word_zx = rdata;
    assign dword   = rdata;
  end

  always_comb begin
    result = word_sx;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   result = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LW:   result = word_sx;
      F3_LD:   result = dword;
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_v};
      F3_LWU:  result = word_zx;
      default: result = word_sx;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage_ctrl.sv
// wb_stage_ctrl: registered RISC-V writeback stage with late-load wait, flush and forwarding outputs.
// Rev 1.0
`default_nettype none

module wb_stage_ctrl
  import riscv_wb_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int RA_W  = 5,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_csr,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_we,
  input  logic [2:0]       in_funct3,
  input  logic [OFF_W-1:0] in_off,
  input  logic             flush,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             pend_valid,
  output logic [RA_W-1:0]  pend_rd
);

  wb_state_e        state;
  logic             ld_we;
  logic [2:0]       ld_funct3;
  logic [OFF_W-1:0] ld_off;
  logic [XLEN-1:0]  sel_data;
  logic [XLEN-1:0]  ld_data;
  logic             accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    sel_data = in_alu;
    case (in_sel)
      WB_PC4:   sel_data = in_pc + XLEN'(4);
      WB_AUIPC: sel_data = in_pc + in_imm;
      WB_CSR:   sel_data = in_csr;
      WB_LUI:   sel_data = in_imm;
      default:  sel_data = in_alu;
    endcase
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata  (mem_rdata),
    .funct3 (ld_funct3),
    .off    (ld_off),
    .result (ld_data)
  );

  // pend_rd doubles as the latched load destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      pend_valid <= 1'b0;
      pend_rd    <= '0;
      ld_we      <= 1'b0;
      ld_funct3  <= '0;
      ld_off     <= '0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_sel == WB_LOAD) begin
              state      <= WAIT_LOAD;
              pend_valid <= 1'b1;
              pend_rd    <= in_rd;
              ld_we      <= in_we;
              ld_funct3  <= in_funct3;
              ld_off     <= in_off;
            end else begin
              rf_we    <= in_we & (in_rd != '0);
              rf_waddr <= in_rd;
              rf_wdata <= sel_data;
            end
          end
        end
        WAIT_LOAD: begin
          if (flush) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
          end else if (mem_rvalid) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            rf_we      <= ld_we & (pend_rd != '0);
            rf_waddr   <= pend_rd;
            rf_wdata   <= ld_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
